// File: rtl/frame_readout_pkg.sv
// Shared types and sizing helpers for the frame readout sequencer.
// Constants depend on instance parameters, so they are exposed as constant functions.
package frame_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LATCH,
    SEND,
    DONE
  } state_e;

  // Counter width for an index range of range_n values, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

  function automatic int unsigned words_per_row(input int unsigned width,
                                                input int unsigned bus_pixels);
    return width / bus_pixels;
  endfunction

endpackage

// File: rtl/readout_row_buffer.sv
// Row capture register and output word selector for the frame readout sequencer.
// Holds one full row of pixel codes and presents one bus word of it at a time.
module readout_row_buffer
  import frame_readout_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 10,
  parameter int WORD_W                 = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        capture,
  input  logic [WIDTH*BIT_DEPTH-1:0]                  row_data,
  input  logic [WORD_W-1:0]                           word_sel,
  output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] word_data
);

  localparam int unsigned ROW_BITS  = WIDTH * BIT_DEPTH;
  localparam int unsigned WORD_BITS = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int unsigned WORDS     = words_per_row(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);

  logic [ROW_BITS-1:0] row_q;
  logic [ROW_BITS-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (capture) begin
      row_d = row_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  // Explicit compare-per-word mux keeps every slice constant and in range.
  always_comb begin
    word_data = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (word_sel == WORD_W'(w)) begin
        word_data = row_q[w*WORD_BITS +: WORD_BITS];
      end
    end
  end

endmodule

// File: rtl/frame_readout_sequencer.sv
// Sequences one frame of pixel-array readout: select row, latch it, stream it out
// as bus words under valid/ready handshake, then pulse FRAME_DONE.
module frame_readout_sequencer
  import frame_readout_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 10
) (
  input  logic                                        SYSTEM_CLK,
  input  logic                                        SYSTEM_RESET,
  input  logic                                        READ_START,
  input  logic [WIDTH*BIT_DEPTH-1:0]                  ROW_DATA,
  input  logic                                        DATA_READY,
  output logic [HEIGHT-1:0]                           ROW_SELECT,
  output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
  output logic                                        DATA_VALID,
  output logic                                        BUSY,
  output logic                                        FRAME_DONE
);

  localparam int unsigned WORDS_PER_ROW = words_per_row(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int unsigned ROW_W         = cnt_width(HEIGHT);
  localparam int unsigned WORD_W        = cnt_width(WORDS_PER_ROW);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);

  if ((WIDTH % OUTPUT_BUS_PIXEL_WIDTH) != 0) begin : g_bad_bus_width
    $error("WIDTH must be an integer multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                capture;
  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] buf_word;

  always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q <= IDLE;
      row_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      word_q  <= word_d;
    end
  end

  // Counters only advance on an accepted word, so they stop at their last index.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (READ_START) begin
          state_d = SELECT;
          row_d   = '0;
          word_d  = '0;
        end
      end
      SELECT: state_d = LATCH;
      LATCH: begin
        word_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (DATA_READY) begin
          if (word_q != LAST_WORD) begin
            word_d = word_q + WORD_W'(1);
          end else if (row_q != LAST_ROW) begin
            row_d   = row_q + ROW_W'(1);
            state_d = SELECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ROW_SELECT = '0;
    DATA_VALID = 1'b0;
    DATA_OUT   = '0;
    BUSY       = (state_q != IDLE);
    FRAME_DONE = (state_q == DONE);
    capture    = (state_q == LATCH);
    if (state_q == SELECT || state_q == LATCH || state_q == SEND) begin
      ROW_SELECT = HEIGHT'(1) << row_q;
    end
    if (state_q == SEND) begin
      DATA_VALID = 1'b1;
      DATA_OUT   = buf_word;
    end
  end

  readout_row_buffer #(
    .WIDTH                 (WIDTH),
    .OUTPUT_BUS_PIXEL_WIDTH(OUTPUT_BUS_PIXEL_WIDTH),
    .BIT_DEPTH             (BIT_DEPTH),
    .WORD_W                (WORD_W)
  ) u_row_buffer (
    .clk      (SYSTEM_CLK),
    .rst      (SYSTEM_RESET),
    .capture  (capture),
    .row_data (ROW_DATA),
    .word_sel (word_q),
    .word_data(buf_word)
  );

endmodule

// File: tb/tb_frame_readout_sequencer.sv
// Scoreboard bench for frame_readout_sequencer: a default instance and a 4-pixel,
// one-pixel-per-word instance, each fed from a modelled pixel array.
module tb_frame_readout_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults (2x2, 2 pixels per word)
  logic        a_start, a_ready;
  logic [19:0] a_row;
  logic [1:0]  a_rsel;
  logic [19:0] a_dout;
  logic        a_valid, a_busy, a_done;
  // Instance B: WIDTH=4, HEIGHT=2, 1 pixel per word
  logic        b_start, b_ready;
  logic [39:0] b_row;
  logic [1:0]  b_rsel;
  logic [9:0]  b_dout;
  logic        b_valid, b_busy, b_done;

  logic [19:0] a_mem [2];
  logic [39:0] b_mem [2];

  typedef struct packed { logic [19:0] word; logic [1:0] rsel; } a_exp_t;
  typedef struct packed { logic [9:0]  word; logic [1:0] rsel; } b_exp_t;
  a_exp_t a_q [$];
  b_exp_t b_q [$];
  a_exp_t a_exp;
  b_exp_t b_exp;

  int errors = 0;
  int checks = 0;
  int a_words = 0, b_words = 0, a_done_cnt = 0, b_done_cnt = 0;
  logic a_done_prev = 1'b0, b_done_prev = 1'b0;

  frame_readout_sequencer dut_a (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_START(a_start), .ROW_DATA(a_row),
    .DATA_READY(a_ready), .ROW_SELECT(a_rsel), .DATA_OUT(a_dout),
    .DATA_VALID(a_valid), .BUSY(a_busy), .FRAME_DONE(a_done)
  );

  frame_readout_sequencer #(
    .WIDTH(4), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(1), .BIT_DEPTH(10)
  ) dut_b (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_START(b_start), .ROW_DATA(b_row),
    .DATA_READY(b_ready), .ROW_SELECT(b_rsel), .DATA_OUT(b_dout),
    .DATA_VALID(b_valid), .BUSY(b_busy), .FRAME_DONE(b_done)
  );

  // Pixel array model: the selected row drives the column bus.
  always_comb begin
    a_row = '0;
    b_row = '0;
    for (int r = 0; r < 2; r++) begin
      if (a_rsel[r]) a_row = a_mem[r];
      if (b_rsel[r]) b_row = b_mem[r];
    end
  end

  // Scoreboard side: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      a_words++;
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_word: got %h sel %b, required no word", a_dout, a_rsel);
      end else begin
        a_exp = a_q.pop_front();
        if ({a_dout, a_rsel} !== {a_exp.word, a_exp.rsel}) begin
          errors++;
          $display("FAIL a_word: got %h sel %b, required %h sel %b",
                   a_dout, a_rsel, a_exp.word, a_exp.rsel);
        end
      end
    end
    if (b_valid && b_ready) begin
      b_words++;
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_word: got %h sel %b, required no word", b_dout, b_rsel);
      end else begin
        b_exp = b_q.pop_front();
        if ({b_dout, b_rsel} !== {b_exp.word, b_exp.rsel}) begin
          errors++;
          $display("FAIL b_word: got %h sel %b, required %h sel %b",
                   b_dout, b_rsel, b_exp.word, b_exp.rsel);
        end
      end
    end
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(a_rsel) || !$onehot0(b_rsel) || (a_valid && !a_busy) || (b_valid && !b_busy) ||
        (a_done && a_done_prev) || (b_done && b_done_prev) ||
        (!a_valid && a_dout !== '0) || (!b_valid && b_dout !== '0)) begin
      errors++;
      $display("FAIL invariant: a sel=%b v=%b busy=%b done=%b/%b out=%h; b sel=%b v=%b busy=%b done=%b/%b out=%h; required onehot0, valid->busy, no double done, out 0 when invalid",
               a_rsel, a_valid, a_busy, a_done, a_done_prev, a_dout,
               b_rsel, b_valid, b_busy, b_done, b_done_prev, b_dout);
    end
    a_done_prev = a_done;
    b_done_prev = b_done;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_rsel, a_dout, a_valid, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got sel=%b out=%h v=%b busy=%b done=%b, required all 0",
               a_rsel, a_dout, a_valid, a_busy, a_done);
    end
    checks++;
    if ({b_rsel, b_dout, b_valid, b_busy, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs: got sel=%b out=%h v=%b busy=%b done=%b, required all 0",
               b_rsel, b_dout, b_valid, b_busy, b_done);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rsel, a_valid, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got sel=%b v=%b busy=%b done=%b, required all 0",
               a_rsel, a_valid, a_busy, a_done);
    end
  endtask

  task automatic test_basic_frame();
    int first_valid = -1, done_at = -1, busy_n = 0, d0, w0;
    a_mem[0] = {10'd3, 10'd1};
    a_mem[1] = {10'd1023, 10'd0};
    a_ready = 1'b1;
    a_q.push_back('{word: {10'd3, 10'd1}, rsel: 2'b01});
    a_q.push_back('{word: {10'd1023, 10'd0}, rsel: 2'b10});
    d0 = a_done_cnt;
    w0 = a_words;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        checks++;
        if (a_rsel !== 2'b01) begin
          errors++;
          $display("FAIL basic_row_select_c%0d: got %b, required 01", k, a_rsel);
        end
      end
      if (a_valid && first_valid < 0) first_valid = k;
      if (a_done) done_at = k;
      if (a_busy) busy_n++;
    end
    checks++;
    if (first_valid !== 3) begin
      errors++;
      $display("FAIL basic_first_valid: got cycle %0d, required 3", first_valid);
    end
    checks++;
    if (done_at !== 7 || busy_n !== 7) begin
      errors++;
      $display("FAIL basic_frame_length: got done at %0d busy %0d, required 7 and 7", done_at, busy_n);
    end
    checks++;
    if (a_done_cnt - d0 !== 1 || a_words - w0 !== 2 || a_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_counts: got done %0d words %0d left %0d, required 1 2 0",
               a_done_cnt - d0, a_words - w0, a_q.size());
    end
  endtask

  task automatic test_narrow_bus();
    int d0, w0;
    b_mem[0] = {10'd40, 10'd30, 10'd20, 10'd10};
    b_mem[1] = {10'd1023, 10'd512, 10'd5, 10'd777};
    b_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        b_q.push_back('{word: b_mem[r][p*10 +: 10], rsel: 2'(1 << r)});
    d0 = b_done_cnt;
    w0 = b_words;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int i = 0; i < 60 && b_done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (b_done_cnt - d0 !== 1 || b_words - w0 !== 8 || b_q.size() !== 0) begin
      errors++;
      $display("FAIL narrow_counts: got done %0d words %0d left %0d, required 1 8 0",
               b_done_cnt - d0, b_words - w0, b_q.size());
    end
  endtask

  task automatic test_backpressure();
    int d0, w0;
    logic [9:0] held;
    b_mem[0] = 40'($urandom) ^ {$urandom, 8'h0};
    b_mem[1] = {10'd9, 10'd8, 10'd7, 10'd6};
    b_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        b_q.push_back('{word: b_mem[r][p*10 +: 10], rsel: 2'(1 << r)});
    d0 = b_done_cnt;
    w0 = b_words;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int i = 0; i < 40 && b_words - w0 < 2; i++) @(posedge clk);
    checks++;
    if (b_words - w0 < 2) begin
      errors++;
      $display("FAIL stall_wait: got %0d words before timeout, required 2", b_words - w0);
    end
    #1 b_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held = b_dout;
      checks++;
      if (b_valid !== 1'b1 || b_dout !== held || b_q.size() == 0 || b_dout !== b_q[0].word) begin
        errors++;
        $display("FAIL stall_stable_c%0d: got v=%b out=%h, required v=1 out=%h",
                 i, b_valid, b_dout, (b_q.size() != 0) ? b_q[0].word : 10'h0);
      end
      @(posedge clk);
    end
    #1 b_ready = 1'b1;
    for (int i = 0; i < 60 && b_done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (b_done_cnt - d0 !== 1 || b_words - w0 !== 8 || b_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_counts: got done %0d words %0d left %0d, required 1 8 0",
               b_done_cnt - d0, b_words - w0, b_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int d0, w0;
    a_mem[0] = 20'($urandom);
    a_mem[1] = 20'($urandom);
    a_ready = 1'b1;
    for (int r = 0; r < 2; r++) a_q.push_back('{word: a_mem[r], rsel: 2'(1 << r)});
    d0 = a_done_cnt;
    w0 = a_words;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) @(negedge clk);
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (25) @(posedge clk);
    checks++;
    if (a_done_cnt - d0 !== 1 || a_words - w0 !== 2 || a_q.size() !== 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got done %0d words %0d left %0d busy %b, required 1 2 0 0",
               a_done_cnt - d0, a_words - w0, a_q.size(), a_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, w0;
    a_mem[0] = 20'h12345;
    a_mem[1] = 20'hABCDE;
    a_ready = 1'b1;
    for (int r = 0; r < 2; r++) a_q.push_back('{word: a_mem[r], rsel: 2'(1 << r)});
    d0 = a_done_cnt;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int i = 0; i < 30 && a_rsel !== 2'b10; i++) @(negedge clk);
    checks++;
    if (a_rsel !== 2'b10) begin
      errors++;
      $display("FAIL abort_wait_row1: got sel %b, required 10", a_rsel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_rsel, a_dout, a_valid, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got sel=%b out=%h v=%b busy=%b done=%b, required all 0",
               a_rsel, a_dout, a_valid, a_busy, a_done);
    end
    a_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    checks++;
    if (a_done_cnt !== d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", a_done_cnt - d0);
    end
    a_mem[0] = {10'd77, 10'd66};
    a_mem[1] = {10'd55, 10'd44};
    a_q.push_back('{word: {10'd77, 10'd66}, rsel: 2'b01});
    a_q.push_back('{word: {10'd55, 10'd44}, rsel: 2'b10});
    w0 = a_words;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int i = 0; i < 30 && a_done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (a_done_cnt - d0 !== 1 || a_words - w0 !== 2 || a_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_fresh_frame: got done %0d words %0d left %0d, required 1 2 0",
               a_done_cnt - d0, a_words - w0, a_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    a_mem[0] = '0; a_mem[1] = '0;
    b_mem[0] = '0; b_mem[1] = '0;
    test_reset();
    test_basic_frame();
    test_narrow_bus();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
